// File: rtl/wb_stage_pkg.sv
// ============================================================================
// Module      : wb_stage_pkg
// Description : Shared bus widths, load-size codes and FSM encodings.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package wb_stage_pkg;

    localparam int REG_BUS_D = 32;
    localparam int REG_BUS_A = 5;

    localparam logic [1:0] LD_BYTE = 2'b00;
    localparam logic [1:0] LD_HALF = 2'b01;
    localparam logic [1:0] LD_WORD = 2'b10;
    localparam logic [1:0] LD_RSVD = 2'b11;

    localparam logic [0:0] ST_IDLE    = 1'b0;
    localparam logic [0:0] ST_WAIT_LD = 1'b1;

endpackage

`default_nettype wire

// File: rtl/wb_stage_load_align.sv
// ============================================================================
// Module      : load_align
// Description : Picks the addressed byte/half of a memory word and extends it.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module load_align
    import wb_stage_pkg::*;
(
    input  logic [REG_BUS_D-1:0] rdata,
    input  logic [1:0]           size,
    input  logic                 uns,
    input  logic [1:0]           addr_lo,
    output logic [REG_BUS_D-1:0] value
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = rdata[{addr_lo, 3'b000} +: 8];
        half_sel = rdata[{addr_lo[1], 4'b0000} +: 16];
        case (size)
            LD_BYTE: value = {{24{~uns & byte_sel[7]}}, byte_sel};
            LD_HALF: value = {{16{~uns & half_sel[15]}}, half_sel};
            default: value = rdata;  // word and reserved encoding
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/wb_stage.sv
// ============================================================================
// Module      : wb_stage
// Description : Writeback stage: retires ALU results directly, loads on rvalid.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module wb_stage
    import wb_stage_pkg::*;
(
    input  logic                 ck_i,
    input  logic                 rs_i,
    input  logic                 in_valid_i,
    output logic                 in_ready_o,
    input  logic                 in_rd_we_i,
    input  logic [REG_BUS_A-1:0] in_rd_wa_i,
    input  logic [REG_BUS_D-1:0] in_rd_wd_i,
    input  logic                 in_is_load_i,
    input  logic [1:0]           in_ld_size_i,
    input  logic                 in_ld_uns_i,
    input  logic [1:0]           in_addr_lo_i,
    input  logic                 dmem_rvalid_i,
    input  logic [REG_BUS_D-1:0] dmem_rdata_i,
    output logic                 rd_we_o,
    output logic [REG_BUS_A-1:0] rd_wa_o,
    output logic [REG_BUS_D-1:0] rd_wd_o,
    output logic                 pend_o,
    output logic [REG_BUS_A-1:0] pend_wa_o,
    output logic                 retire_o,
    output logic [63:0]          instret_o
);

    logic [0:0]           state;
    logic [0:0]           next_state;
    logic                 accept_alu;
    logic                 accept_ld;
    logic                 complete_ld;
    logic                 ld_we;
    logic [REG_BUS_A-1:0] ld_wa;
    logic [1:0]           ld_size;
    logic                 ld_uns;
    logic [1:0]           ld_addr_lo;
    logic [REG_BUS_D-1:0] aligned;
    logic [63:0]          instret;

    always_ff @(posedge ck_i or posedge rs_i) begin
        if (rs_i) state <= ST_IDLE;
        else      state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE:    if (in_valid_i && in_is_load_i) next_state = ST_WAIT_LD;
            ST_WAIT_LD: if (dmem_rvalid_i)              next_state = ST_IDLE;
            default:                                    next_state = ST_IDLE;
        endcase
    end

    always_comb begin
        in_ready_o  = (state == ST_IDLE);
        accept_alu  = (state == ST_IDLE) && in_valid_i && !in_is_load_i;
        accept_ld   = (state == ST_IDLE) && in_valid_i && in_is_load_i;
        complete_ld = (state == ST_WAIT_LD) && dmem_rvalid_i;
        pend_o      = (state == ST_WAIT_LD) && ld_we && (ld_wa != '0);
        pend_wa_o   = ld_wa;
    end

    // Alignment uses the attributes captured at acceptance, not the live inputs.
    load_align u_load_align (
        .rdata   (dmem_rdata_i),
        .size    (ld_size),
        .uns     (ld_uns),
        .addr_lo (ld_addr_lo),
        .value   (aligned)
    );

    always_ff @(posedge ck_i or posedge rs_i) begin
        if (rs_i) begin
            ld_we      <= 1'b0;
            ld_wa      <= '0;
            ld_size    <= LD_WORD;
            ld_uns     <= 1'b0;
            ld_addr_lo <= 2'b00;
            rd_we_o    <= 1'b0;
            rd_wa_o    <= '0;
            rd_wd_o    <= '0;
            retire_o   <= 1'b0;
            instret    <= '0;
        end else begin
            rd_we_o  <= 1'b0;
            retire_o <= 1'b0;
            if (accept_ld) begin
                ld_we      <= in_rd_we_i;
                ld_wa      <= in_rd_wa_i;
                ld_size    <= in_ld_size_i;
                ld_uns     <= in_ld_uns_i;
                ld_addr_lo <= in_addr_lo_i;
            end
            if (accept_alu) begin
                rd_we_o  <= in_rd_we_i && (in_rd_wa_i != '0);
                rd_wa_o  <= in_rd_wa_i;
                rd_wd_o  <= in_rd_wd_i;
                retire_o <= 1'b1;
                instret  <= instret + 64'd1;
            end else if (complete_ld) begin
                rd_we_o  <= ld_we && (ld_wa != '0);
                rd_wa_o  <= ld_wa;
                rd_wd_o  <= aligned;
                retire_o <= 1'b1;
                instret  <= instret + 64'd1;
            end
        end
    end

    assign instret_o = instret;

endmodule

`default_nettype wire

// File: tb/tb_wb_stage.sv
// ============================================================================
// Module      : tb_wb_stage
// Description : Self-checking bench for wb_stage against a transaction model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_wb_stage;

    logic        ck_i = 1'b0;
    logic        rs_i = 1'b1;
    logic        in_valid_i = 1'b0;
    logic        in_ready_o;
    logic        in_rd_we_i = 1'b0;
    logic [4:0]  in_rd_wa_i = '0;
    logic [31:0] in_rd_wd_i = '0;
    logic        in_is_load_i = 1'b0;
    logic [1:0]  in_ld_size_i = '0;
    logic        in_ld_uns_i = 1'b0;
    logic [1:0]  in_addr_lo_i = '0;
    logic        dmem_rvalid_i = 1'b0;
    logic [31:0] dmem_rdata_i = '0;
    logic        rd_we_o;
    logic [4:0]  rd_wa_o;
    logic [31:0] rd_wd_o;
    logic        pend_o;
    logic [4:0]  pend_wa_o;
    logic        retire_o;
    logic [63:0] instret_o;

    wb_stage dut (
        .ck_i          (ck_i),
        .rs_i          (rs_i),
        .in_valid_i    (in_valid_i),
        .in_ready_o    (in_ready_o),
        .in_rd_we_i    (in_rd_we_i),
        .in_rd_wa_i    (in_rd_wa_i),
        .in_rd_wd_i    (in_rd_wd_i),
        .in_is_load_i  (in_is_load_i),
        .in_ld_size_i  (in_ld_size_i),
        .in_ld_uns_i   (in_ld_uns_i),
        .in_addr_lo_i  (in_addr_lo_i),
        .dmem_rvalid_i (dmem_rvalid_i),
        .dmem_rdata_i  (dmem_rdata_i),
        .rd_we_o       (rd_we_o),
        .rd_wa_o       (rd_wa_o),
        .rd_wd_o       (rd_wd_o),
        .pend_o        (pend_o),
        .pend_wa_o     (pend_wa_o),
        .retire_o      (retire_o),
        .instret_o     (instret_o)
    );

    always #5 ck_i = ~ck_i;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [63:0] exp_instret = '0;
    logic [4:0]  exp_wa = '0;
    logic [31:0] exp_wd = '0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Extract field by shift/mask, then sign-extend by subtracting 2^width.
    function automatic logic [31:0] ref_align(input logic [31:0] rdata, input int size,
                                              input bit uns, input int addr);
        longint unsigned raw;
        int width;
        int shift;
        case (size)
            0:       begin width = 8;  shift = 8 * addr; end
            1:       begin width = 16; shift = 16 * (addr / 2); end
            default: begin width = 32; shift = 0; end
        endcase
        raw = (longint'(rdata) >> shift) & ((64'd1 << width) - 64'd1);
        if (!uns && width < 32 && raw >= (64'd1 << (width - 1)))
            raw = raw - (64'd1 << width);
        return raw[31:0];
    endfunction

    task automatic drive_junk(input bit valid);
        in_valid_i   = valid;
        in_is_load_i = 1'b0;
        in_rd_we_i   = 1'b1;
        in_rd_wa_i   = 5'(1 + $urandom_range(0, 30));
        in_rd_wd_i   = $urandom;
        in_ld_size_i = 2'($urandom_range(0, 3));
        in_ld_uns_i  = 1'($urandom_range(0, 1));
        in_addr_lo_i = 2'($urandom_range(0, 3));
    endtask

    task automatic idle_cycle(input bit stray);
        drive_junk(1'b0);
        dmem_rvalid_i = stray;
        dmem_rdata_i  = $urandom;
        @(posedge ck_i); #1;
        dmem_rvalid_i = 1'b0;
        check("idle_we", 64'(rd_we_o), 64'd0);
        check("idle_retire", 64'(retire_o), 64'd0);
        check("idle_instret", instret_o, exp_instret);
        check("idle_wa_hold", 64'(rd_wa_o), 64'(exp_wa));
        check("idle_wd_hold", 64'(rd_wd_o), 64'(exp_wd));
        check("idle_ready", 64'(in_ready_o), 64'd1);
    endtask

    task automatic do_alu(input bit we, input logic [4:0] wa, input logic [31:0] wd);
        check("alu_ready_in", 64'(in_ready_o), 64'd1);
        drive_junk(1'b1);
        in_rd_we_i = we;
        in_rd_wa_i = wa;
        in_rd_wd_i = wd;
        @(posedge ck_i); #1;
        drive_junk(1'b0);
        exp_instret = exp_instret + 64'd1;
        exp_wa = wa;
        exp_wd = wd;
        check("alu_we", 64'(rd_we_o), 64'(we && wa != 0));
        check("alu_wa", 64'(rd_wa_o), 64'(wa));
        check("alu_wd", 64'(rd_wd_o), 64'(wd));
        check("alu_retire", 64'(retire_o), 64'd1);
        check("alu_instret", instret_o, exp_instret);
    endtask

    task automatic do_load(input bit we, input logic [4:0] wa, input int size, input bit uns,
                           input int addr, input int waits, input logic [31:0] rdata);
        check("ld_ready_in", 64'(in_ready_o), 64'd1);
        drive_junk(1'b1);
        in_is_load_i = 1'b1;
        in_rd_we_i   = we;
        in_rd_wa_i   = wa;
        in_ld_size_i = 2'(size);
        in_ld_uns_i  = uns;
        in_addr_lo_i = 2'(addr);
        @(posedge ck_i); #1;
        for (int i = 0; i <= waits; i++) begin
            check("ld_wait_ready", 64'(in_ready_o), 64'd0);
            check("ld_wait_we", 64'(rd_we_o), 64'd0);
            check("ld_pend", 64'(pend_o), 64'(we && wa != 0));
            check("ld_pend_wa", 64'(pend_wa_o), 64'(wa));
            // Offer a competing instruction that must not be accepted.
            drive_junk(1'b1);
            if (i == waits) begin
                dmem_rvalid_i = 1'b1;
                dmem_rdata_i  = rdata;
            end
            @(posedge ck_i); #1;
        end
        dmem_rvalid_i = 1'b0;
        dmem_rdata_i  = $urandom;
        drive_junk(1'b0);
        exp_instret = exp_instret + 64'd1;
        exp_wa = wa;
        exp_wd = ref_align(rdata, size, uns, addr);
        check("ld_we", 64'(rd_we_o), 64'(we && wa != 0));
        check("ld_wa", 64'(rd_wa_o), 64'(wa));
        check("ld_wd", 64'(rd_wd_o), 64'(exp_wd));
        check("ld_retire", 64'(retire_o), 64'd1);
        check("ld_instret", instret_o, exp_instret);
        check("ld_pend_clr", 64'(pend_o), 64'd0);
        check("ld_ready_out", 64'(in_ready_o), 64'd1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(posedge ck_i);
        #1;
        check("rst_we", 64'(rd_we_o), 64'd0);
        check("rst_wa", 64'(rd_wa_o), 64'd0);
        check("rst_wd", 64'(rd_wd_o), 64'd0);
        check("rst_pend", 64'(pend_o), 64'd0);
        check("rst_pend_wa", 64'(pend_wa_o), 64'd0);
        check("rst_retire", 64'(retire_o), 64'd0);
        check("rst_instret", instret_o, 64'd0);
        check("rst_ready", 64'(in_ready_o), 64'd1);
        rs_i = 1'b0;

        // First edge after reset release accepts immediately.
        do_alu(1'b1, 5'd5, 32'h1234_5678);
        check("add_instret_is_1", instret_o, 64'd1);

        do_load(1'b1, 5'd7, 0, 1'b0, 3, 3, 32'h80FF_0011);
        check("lb_value", 64'(rd_wd_o), 64'hFFFF_FF80);
        do_load(1'b1, 5'd8, 1, 1'b1, 2, 0, 32'hBEEF_1234);
        check("lhu_value", 64'(rd_wd_o), 64'h0000_BEEF);
        do_load(1'b1, 5'd8, 1, 1'b0, 2, 1, 32'hBEEF_1234);
        check("lh_value", 64'(rd_wd_o), 64'hFFFF_BEEF);
        do_load(1'b1, 5'd9, 2, 1'b0, 1, 2, 32'hBEEF_1234);
        check("lw_value", 64'(rd_wd_o), 64'hBEEF_1234);
        do_load(1'b1, 5'd10, 3, 1'b1, 2, 0, 32'hCAFE_0042);
        do_load(1'b1, 5'd0, 0, 1'b1, 0, 1, 32'h0000_00AA);

        do_alu(1'b1, 5'd0, 32'hDEAD_BEEF);
        do_alu(1'b0, 5'd3, 32'h0BAD_F00D);
        idle_cycle(1'b1);

        for (int n = 0; n < 60; n++) begin
            int kind;
            kind = $urandom_range(0, 9);
            if (kind < 5)
                do_alu(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom);
            else if (kind < 8)
                do_load(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
                        $urandom_range(0, 3), 1'($urandom_range(0, 1)),
                        $urandom_range(0, 3), $urandom_range(0, 4), $urandom);
            else
                idle_cycle(1'($urandom_range(0, 1)));
        end

        // Reset in the middle of an outstanding load.
        drive_junk(1'b1);
        in_is_load_i = 1'b1;
        in_rd_wa_i   = 5'd12;
        @(posedge ck_i); #1;
        drive_junk(1'b0);
        @(posedge ck_i); #1;
        check("pre_rst_pend", 64'(pend_o), 64'd1);
        rs_i = 1'b1;
        #1;
        check("arst_ready", 64'(in_ready_o), 64'd1);
        check("arst_pend", 64'(pend_o), 64'd0);
        check("arst_instret", instret_o, 64'd0);
        check("arst_wd", 64'(rd_wd_o), 64'd0);
        exp_instret = '0;
        exp_wa = '0;
        exp_wd = '0;
        @(posedge ck_i); #1;
        rs_i = 1'b0;
        idle_cycle(1'b1);

        // Counter wrap from all-ones.
        force dut.instret = 64'hFFFF_FFFF_FFFF_FFFF;
        #2;
        release dut.instret;
        check("instret_forced", instret_o, 64'hFFFF_FFFF_FFFF_FFFF);
        exp_instret = 64'hFFFF_FFFF_FFFF_FFFF;
        do_alu(1'b1, 5'd4, 32'h0000_0001);
        check("instret_wrap", instret_o, 64'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
